// File: rtl/fb_writer_pkg.sv
// Shared raster types and defaults for the framebuffer writer.
// Defines COLOR_BITS, FB_WIDTH_DEFAULT and FB_HEIGHT_DEFAULT, and the coordinate type.
// Pure declarations only: no logic, no latency, no flow control.
`ifndef COLOR_BITS
`define COLOR_BITS 8
`endif
`ifndef FB_WIDTH_DEFAULT
`define FB_WIDTH_DEFAULT 320
`endif
`ifndef FB_HEIGHT_DEFAULT
`define FB_HEIGHT_DEFAULT 240
`endif

package fb_writer_pkg;

  localparam int COORD_BITS = 16;

  // Screen coordinate; both halves are two's-complement so off-screen
  // (negative) positions from the rasterizer survive intact.
  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
  } coord_2d_t;

endpackage

// File: rtl/fb_writer_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO (WIDTH x DEPTH, DEPTH a power of two).
// Latency: a word pushed at edge N is visible on pop_data_o right after edge N.
// Backpressure: caller must not push when full_o; pop is ignored when empty_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

  // Storage and pointer update; reset discards all content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: bounds-check pixels, map x/y to a word address, queue and write them; owns the clear sweep.
// Latency: pixel accepted at edge N drives mem_wr_vld after edge N when the FIFO was empty.
// Backpressure: rdy_in drops when the FIFO is full or a clear is pending; FIFO holds writes while mem_wr_rdy=0.
// Optional: define FB_WRITER_DROP_CNT_EN to add the saturating drop_count output.
module fb_writer
  import fb_writer_pkg::*;
#(
  parameter int FB_WIDTH   = `FB_WIDTH_DEFAULT,
  parameter int FB_HEIGHT  = `FB_HEIGHT_DEFAULT,
  parameter int ADDR_BITS  = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vld_in,
  output logic                   rdy_in,
  input  logic [`COLOR_BITS-1:0] color_in,
  input  coord_2d_t              pixel_in,
  input  logic                   clear_req,
  input  logic [`COLOR_BITS-1:0] clear_color,
  output logic                   clear_busy,
  output logic                   mem_wr_vld,
  input  logic                   mem_wr_rdy,
  output logic [ADDR_BITS-1:0]   mem_wr_addr,
  output logic [`COLOR_BITS-1:0] mem_wr_data
`ifdef FB_WRITER_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} fb_writer_state_t;

  localparam int                           EW        = ADDR_BITS + `COLOR_BITS;
  localparam logic [ADDR_BITS-1:0]         LAST_ADDR = ADDR_BITS'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0]         WIDTH_A   = ADDR_BITS'(FB_WIDTH);
  localparam logic signed [COORD_BITS-1:0] ZERO_S    = '0;
  localparam logic signed [COORD_BITS-1:0] WIDTH_S   = COORD_BITS'(FB_WIDTH);
  localparam logic signed [COORD_BITS-1:0] HEIGHT_S  = COORD_BITS'(FB_HEIGHT);

  fb_writer_state_t       state_q;
  logic                   clear_pending_q;
  logic [ADDR_BITS-1:0]   clr_ptr_q;
  logic [`COLOR_BITS-1:0] clr_color_q;

  logic                   fifo_full, fifo_empty;
  logic [EW-1:0]          fifo_head;
  logic                   in_range, accept, push, pop;
  logic [ADDR_BITS-1:0]   pix_addr;

  // Signed compares so negative coordinates are rejected rather than wrapping.
  assign in_range = (pixel_in.x >= ZERO_S) && (pixel_in.x < WIDTH_S) &&
                    (pixel_in.y >= ZERO_S) && (pixel_in.y < HEIGHT_S);
  // Only meaningful when in_range, so truncating to ADDR_BITS is safe.
  assign pix_addr = ADDR_BITS'(pixel_in.y) * WIDTH_A + ADDR_BITS'(pixel_in.x);

  // rst_n term keeps the rasterizer stalled for the whole reset window.
  assign rdy_in     = rst_n && (state_q == RUN) && !fifo_full && !clear_pending_q;
  assign accept     = vld_in && rdy_in;
  assign push       = accept && in_range;
  assign pop        = (state_q != CLEAR) && !fifo_empty && mem_wr_rdy;
  assign clear_busy = (state_q != RUN);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({pix_addr, color_in}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Write port mux: clear sweep owns the port in CLEAR, otherwise the FIFO head; idle outputs read zero.
  always_comb begin
    mem_wr_vld  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state_q == CLEAR) begin
      mem_wr_vld  = 1'b1;
      mem_wr_addr = clr_ptr_q;
      mem_wr_data = clr_color_q;
    end else if (!fifo_empty) begin
      mem_wr_vld                 = 1'b1;
      {mem_wr_addr, mem_wr_data} = fifo_head;
    end
  end

  // Control FSM: RUN -> DRAIN (flush queued pixels) -> CLEAR (sweep all addresses) -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      clear_pending_q <= 1'b0;
      clr_ptr_q       <= '0;
      clr_color_q     <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (clear_req) begin
            clear_pending_q <= 1'b1;
            state_q         <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            clr_color_q <= clear_color;
            clr_ptr_q   <= '0;
            state_q     <= CLEAR;
          end
        end
        CLEAR: begin
          if (mem_wr_rdy) begin
            if (clr_ptr_q == LAST_ADDR) begin
              clr_ptr_q       <= '0;
              clear_pending_q <= 1'b0;
              state_q         <= RUN;
            end else begin
              clr_ptr_q <= clr_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef FB_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  assign drop_count = drop_cnt_q;

  // Count accepted off-screen pixels, saturating; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && !in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer with a queue-based scoreboard and a small
// screen so that full clear sweeps stay short.
// Drives on posedge+1, decides/compares on the following negedge.
module tb_fb_writer;
  import fb_writer_pkg::*;

  localparam int W   = 12;
  localparam int H   = 5;
  localparam int AB  = 7;
  localparam int DEP = 4;
  localparam int CB  = `COLOR_BITS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           vld_in = 1'b0;
  logic           rdy_in;
  logic [CB-1:0]  color_in = '0;
  coord_2d_t      pixel_in = '0;
  logic           clear_req = 1'b0;
  logic [CB-1:0]  clear_color = '0;
  logic           clear_busy;
  logic           mem_wr_vld;
  logic           mem_wr_rdy = 1'b0;
  logic [AB-1:0]  mem_wr_addr;
  logic [CB-1:0]  mem_wr_data;
`ifdef FB_WRITER_DROP_CNT_EN
  logic [15:0]    drop_count;
`endif

  always #5 clk = ~clk;

  fb_writer #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .ADDR_BITS  (AB),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld_in      (vld_in),
    .rdy_in      (rdy_in),
    .color_in    (color_in),
    .pixel_in    (pixel_in),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .mem_wr_vld  (mem_wr_vld),
    .mem_wr_rdy  (mem_wr_rdy),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
`ifdef FB_WRITER_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [CB-1:0] data;
    bit            clr;
    bit            last;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  m_busy   = 0;   // model: a clear has been requested and its sweep is not yet fully written
  int  m_pix    = 0;   // model: accepted in-range pixels not yet written
  int  m_drop   = 0;
  int  clr_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (x < W) && (y >= 0) && (y < H);
  endfunction

  // One clock of stimulus plus the per-cycle model update and handshake checks.
  task automatic cycle(input logic v, input int x, input int y, input logic [CB-1:0] c,
                       input logic cr, input logic [CB-1:0] cc, input logic mr, output logic acc);
    wr_t e;
    @(posedge clk); #1;
    vld_in     = v;
    pixel_in.x = 16'(x);
    pixel_in.y = 16'(y);
    color_in   = c;
    clear_req  = cr;
    mem_wr_rdy = mr;
    if (!m_busy) clear_color = cc;
    @(negedge clk);
    chk("rdy_in", {31'd0, rdy_in}, {31'd0, (!m_busy && m_pix < DEP)});
    chk("clear_busy", {31'd0, clear_busy}, {31'd0, m_busy});
`ifdef FB_WRITER_DROP_CNT_EN
    chk("drop_count", {16'd0, drop_count}, 32'(m_drop));
`endif
    acc = v && rdy_in;
    if (acc) begin
      if (on_screen(x, y)) begin
        e.addr = AB'(y * W + x);
        e.data = c;
        e.clr  = 0;
        e.last = 0;
        exp_q.push_back(e);
        m_pix++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (cr && !m_busy) begin
      m_busy = 1;
      for (int a = 0; a < W * H; a++) begin
        e.addr = AB'(a);
        e.data = clear_color;
        e.clr  = 1;
        e.last = (a == W * H - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic mr);
    logic acc;
    cycle(0, 0, 0, '0, 0, '0, mr, acc);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || m_busy) && guard < 400) begin
      idle(1);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    vld_in    = 1'b0;
    clear_req = 1'b0;
    #1;
    chk("rst_rdy_in", {31'd0, rdy_in}, 32'd0);
    chk("rst_mem_wr_vld", {31'd0, mem_wr_vld}, 32'd0);
    chk("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    exp_q.delete();
    m_busy = 0;
    m_pix  = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every presented write must match the scoreboard head; pop on handshake.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && mem_wr_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                   mem_wr_addr, mem_wr_data, $time);
        end else begin
          chk("wr_addr", 32'(mem_wr_addr), 32'(exp_q[0].addr));
          chk("wr_data", 32'(mem_wr_data), 32'(exp_q[0].data));
          if (mem_wr_rdy) begin
            e = exp_q.pop_front();
            if (e.clr) begin
              clr_seen++;
              if (e.last) m_busy = 0;
            end else begin
              m_pix--;
            end
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    int   k;
    int   guard;

    // Reset values while held in reset.
    #2;
    chk("init_rdy_in", {31'd0, rdy_in}, 32'd0);
    chk("init_mem_wr_vld", {31'd0, mem_wr_vld}, 32'd0);
    chk("init_clear_busy", {31'd0, clear_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single pixel: write appears one cycle after acceptance.
    cycle(1, 3, 2, 8'hA5, 0, '0, 1, acc);
    chk("single_acc", {31'd0, acc}, 32'd1);
    chk("single_vld_same_cycle", {31'd0, mem_wr_vld}, 32'd0);
    idle(1);
    chk("single_vld_next", {31'd0, mem_wr_vld}, 32'd1);
    chk("single_addr", 32'(mem_wr_addr), 32'(2 * W + 3));
    drain();

    // Off-screen pixels are accepted and silently dropped.
    cycle(1, W, 0, 8'h11, 0, '0, 1, acc);
    chk("oor_right_acc", {31'd0, acc}, 32'd1);
    cycle(1, -1, 5, 8'h22, 0, '0, 1, acc);
    chk("oor_neg_acc", {31'd0, acc}, 32'd1);
    cycle(1, 0, H, 8'h33, 0, '0, 1, acc);
    chk("oor_bottom_acc", {31'd0, acc}, 32'd1);
    drain();
`ifdef FB_WRITER_DROP_CNT_EN
    chk("drop_three", {16'd0, drop_count}, 32'd3);
`endif

    // Backpressure: only DEP pixels fit while memory stalls.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, k, 1, CB'(8'h40 + k), 0, '0, 0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", 32'(k), 32'(DEP));
    guard = 0;
    while (k < 6 && guard < 50) begin
      cycle(1, k, 1, CB'(8'h40 + k), 0, '0, 1, acc);
      if (acc) k++;
      guard++;
    end
    chk("bp_all_accepted", 32'(k), 32'd6);
    drain();

    // Clear with two pixels queued ahead of it.
    cycle(1, 1, 0, 8'h77, 0, '0, 0, acc);
    cycle(1, 2, 4, 8'h78, 0, '0, 0, acc);
    cycle(0, 0, 0, '0, 1, 8'h1F, 0, acc);
    drain();

    // Clear under toggling memory ready; a second request mid-sweep is ignored.
    clr_seen = 0;
    cycle(0, 0, 0, '0, 1, 8'h5C, 1, acc);
    for (int i = 0; i < 40; i++) cycle(1, 0, 0, 8'h99, (i == 12), 8'hEE, i[0], acc);
    drain();
    chk("clear_write_count", 32'(clr_seen), 32'(W * H));

    // Reset in the middle of a sweep after three clear writes.
    clr_seen = 0;
    cycle(0, 0, 0, '0, 1, 8'h33, 1, acc);
    guard = 0;
    while (clr_seen < 3 && guard < 50) begin
      idle(1);
      guard++;
    end
    chk("mid_clear_progress", 32'(clr_seen), 32'd3);
    do_reset();
    for (int i = 0; i < 5; i++) idle(1);

    // Randomised traffic including off-screen pixels, stalls and clears.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0,
            int'($urandom_range(0, W + 3)) - 2,
            int'($urandom_range(0, H + 3)) - 2,
            CB'($urandom),
            $urandom_range(0, 149) == 0,
            CB'($urandom),
            $urandom_range(0, 3) != 0,
            acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
